// File: rtl/alu_exec_stage.sv
// Execute/writeback stage in front of an external combinational 8-bit ALU.
// Each instruction takes three cycles: accept (IDLE), ALU settle (EXEC), writeback (WB).
module alu_exec_stage #(
  parameter int NREGS               = 8,
  parameter bit FLAG_CV_ADDSUB_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_ina,
  output logic [7:0]  alu_inb,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [7:0]  alu_out,
  input  logic        alu_cr,
  input  logic        alu_ov,
  input  logic        alu_ng,
  input  logic        alu_zr,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  flags,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LS  = 4'b0011;
  localparam logic [3:0] OP_SRS = 4'b0100;
  localparam logic [3:0] OP_URS = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_RRO = 4'b1000;
  localparam logic [3:0] OP_LRO = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_regs [NREGS];
  logic [7:0]  r_opa;
  logic [7:0]  r_opb;
  logic [3:0]  r_op;
  logic [4:0]  r_shamt;
  logic [2:0]  r_rd;
  logic [3:0]  r_flags;

  logic [3:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [7:0]  w_rs1_val;
  logic [7:0]  w_rs2_val;
  logic        w_is_shift;
  logic        w_accept;
  logic        w_legal;
  logic        w_cv_upd;
  logic        w_wb;

  assign w_op  = instr[15:12];
  assign w_rd  = instr[11:9];
  assign w_rs1 = instr[8:6];
  assign w_rs2 = instr[5:3];

  // r0 and any address beyond the implemented file read as zero
  function automatic logic [7:0] rf_read(input logic [2:0] addr);
    logic [7:0] val;
    val = 8'h00;
    if (addr != 3'd0 && {29'd0, addr} < NREGS) val = r_regs[addr];
    return val;
  endfunction

  assign w_rs1_val  = rf_read(w_rs1);
  assign w_rs2_val  = rf_read(w_rs2);
  assign dbg_data   = rf_read(dbg_addr);
  assign w_is_shift = (w_op == OP_LS) || (w_op == OP_URS) || (w_op == OP_SRS) ||
                      (w_op == OP_RRO) || (w_op == OP_LRO);
  assign w_accept   = instr_valid && instr_ready;

  always_comb begin
    w_legal = 1'b0;
    case (r_op)
      OP_AND, OP_OR, OP_ADD, OP_LS, OP_SRS, OP_URS,
      OP_SUB, OP_SLT, OP_RRO, OP_LRO, OP_NOT: w_legal = 1'b1;
      default:                                 w_legal = 1'b0;
    endcase
  end

  assign w_cv_upd = !FLAG_CV_ADDSUB_ONLY || (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_wb     = (r_state == S_WB) && !rst;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs; a reset in WB suppresses the pulse
  always_comb begin
    instr_ready = (r_state == S_IDLE);
    done        = w_wb;
    illegal     = w_wb && !w_legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
      r_opa   <= 8'h00;
      r_opb   <= 8'h00;
      r_op    <= OP_AND;
      r_shamt <= 5'd0;
      r_rd    <= 3'd0;
      r_flags <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_opa   <= w_rs1_val;
        r_opb   <= w_rs2_val;
        r_op    <= w_op;
        r_shamt <= w_is_shift ? instr[4:0] : 5'd0;
        r_rd    <= w_rd;
      end
      if (r_state == S_WB && w_legal) begin
        if (r_rd != 3'd0 && {29'd0, r_rd} < NREGS) r_regs[r_rd] <= alu_out;
        r_flags[1] <= alu_ng;
        r_flags[0] <= alu_zr;
        if (w_cv_upd) begin
          r_flags[3] <= alu_cr;
          r_flags[2] <= alu_ov;
        end
      end
    end
  end

  assign alu_ina   = r_opa;
  assign alu_inb   = r_opb;
  assign alu_op    = r_op;
  assign alu_shamt = r_shamt;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural 8-bit ALU attached to its ALU ports.
// Expected register and flag values below are hand-computed.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_ina;
  logic [7:0]  alu_inb;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [7:0]  alu_out;
  logic        alu_cr;
  logic        alu_ov;
  logic        alu_ng;
  logic        alu_zr;
  logic        done;
  logic        illegal;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_ina     (alu_ina),
    .alu_inb     (alu_inb),
    .alu_op      (alu_op),
    .alu_shamt   (alu_shamt),
    .alu_out     (alu_out),
    .alu_cr      (alu_cr),
    .alu_ov      (alu_ov),
    .alu_ng      (alu_ng),
    .alu_zr      (alu_zr),
    .done        (done),
    .illegal     (illegal),
    .flags       (flags),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: carry/overflow only meaningful for ADD/SUB, 0 otherwise
  logic [8:0]  m_sum;
  logic [15:0] m_rot;
  always_comb begin
    m_sum   = 9'd0;
    m_rot   = 16'd0;
    alu_out = 8'h00;
    alu_cr  = 1'b0;
    alu_ov  = 1'b0;
    case (alu_op)
      4'b0010: begin
        m_sum   = {1'b0, alu_ina} + {1'b0, alu_inb};
        alu_out = m_sum[7:0];
        alu_cr  = m_sum[8];
        alu_ov  = (alu_ina[7] == alu_inb[7]) && (m_sum[7] != alu_ina[7]);
      end
      4'b0110: begin
        m_sum   = {1'b0, alu_ina} + {1'b0, ~alu_inb} + 9'd1;
        alu_out = m_sum[7:0];
        alu_cr  = m_sum[8];
        alu_ov  = (alu_ina[7] != alu_inb[7]) && (m_sum[7] != alu_ina[7]);
      end
      4'b0000: alu_out = alu_ina & alu_inb;
      4'b0001: alu_out = alu_ina | alu_inb;
      4'b1111: alu_out = ~alu_ina;
      4'b0111: alu_out = ($signed(alu_ina) < $signed(alu_inb)) ? 8'h01 : 8'h00;
      4'b0011: alu_out = alu_ina << alu_shamt;
      4'b0101: alu_out = alu_ina >> alu_shamt;
      4'b0100: alu_out = 8'($signed(alu_ina) >>> alu_shamt);
      4'b1000: begin
        m_rot   = {alu_ina, alu_ina} >> alu_shamt[2:0];
        alu_out = m_rot[7:0];
      end
      4'b1001: begin
        m_rot   = {alu_ina, alu_ina} << alu_shamt[2:0];
        alu_out = m_rot[15:8];
      end
      default: alu_out = 8'h00;
    endcase
  end
  assign alu_ng = alu_out[7];
  assign alu_zr = (alu_out == 8'h00);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, {8'h00, dbg_data}, {8'h00, exp});
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] mk_sh(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [4:0] sh);
    return {op, rd, rs1, 1'b0, sh};
  endfunction

  // Full accept -> EXEC -> WB -> IDLE sequence, sampled on falling edges
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic exp_ill,
                           input logic [7:0] exp_a, input logic [4:0] exp_sh);
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    chk({tag, "_ready_idle"}, {15'd0, instr_ready}, 16'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_ready_exec"}, {15'd0, instr_ready}, 16'd0);
    chk({tag, "_done_exec"}, {15'd0, done}, 16'd0);
    chk({tag, "_ina_exec"}, {8'h00, alu_ina}, {8'h00, exp_a});
    chk({tag, "_shamt_exec"}, {11'd0, alu_shamt}, {11'd0, exp_sh});
    @(negedge clk);
    chk({tag, "_done_wb"}, {15'd0, done}, 16'd1);
    chk({tag, "_illegal_wb"}, {15'd0, illegal}, {15'd0, exp_ill});
    @(negedge clk);
    chk({tag, "_done_after"}, {15'd0, done}, 16'd0);
    chk({tag, "_ready_after"}, {15'd0, instr_ready}, 16'd1);
    $display("txn %s instr=%04h done", tag, ins);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_alu_op", {12'd0, alu_op}, 16'd0);
    chk("rst_alu_ina", {8'h00, alu_ina}, 16'd0);
    chk("rst_alu_inb", {8'h00, alu_inb}, 16'd0);
    chk("rst_shamt", {11'd0, alu_shamt}, 16'd0);
    chk_reg("rst_r1", 3'd1, 8'h00);

    run_instr("add_r1", mk(4'b0010, 3'd1, 3'd0, 3'd0), 1'b0, 8'h00, 5'd0);
    chk_reg("add_r1_val", 3'd1, 8'h00);
    chk("add_r1_flags", {12'd0, flags}, 16'b0001);

    run_instr("not_r1", mk(4'b1111, 3'd1, 3'd0, 3'd0), 1'b0, 8'h00, 5'd0);
    chk_reg("not_r1_val", 3'd1, 8'hFF);
    chk("not_r1_flags", {12'd0, flags}, 16'b0010);

    run_instr("slt_r3", mk(4'b0111, 3'd3, 3'd1, 3'd0), 1'b0, 8'hFF, 5'd0);
    chk_reg("slt_r3_val", 3'd3, 8'h01);
    chk("slt_r3_flags", {12'd0, flags}, 16'b0000);

    run_instr("urs_r2", mk_sh(4'b0101, 3'd2, 3'd1, 5'd1), 1'b0, 8'hFF, 5'd1);
    chk_reg("urs_r2_val", 3'd2, 8'h7F);

    run_instr("add_r4", mk(4'b0010, 3'd4, 3'd2, 3'd3), 1'b0, 8'h7F, 5'd0);
    chk_reg("add_r4_val", 3'd4, 8'h80);
    chk("add_r4_flags", {12'd0, flags}, 16'b0110);

    run_instr("sub_r5", mk(4'b0110, 3'd5, 3'd3, 3'd3), 1'b0, 8'h01, 5'd0);
    chk_reg("sub_r5_val", 3'd5, 8'h00);
    chk("sub_r5_flags", {12'd0, flags}, 16'b1001);

    run_instr("and_r6", mk(4'b0000, 3'd6, 3'd1, 3'd4), 1'b0, 8'hFF, 5'd0);
    chk_reg("and_r6_val", 3'd6, 8'h80);
    chk("and_r6_flags", {12'd0, flags}, 16'b1010);

    run_instr("urs_r2b", mk_sh(4'b0101, 3'd2, 3'd1, 5'd4), 1'b0, 8'hFF, 5'd4);
    chk_reg("urs_r2b_val", 3'd2, 8'h0F);
    chk("urs_r2b_flags", {12'd0, flags}, 16'b1000);

    run_instr("ls_r6", mk_sh(4'b0011, 3'd6, 3'd2, 5'd3), 1'b0, 8'h0F, 5'd3);
    chk_reg("ls_r6_val", 3'd6, 8'h78);
    chk("ls_r6_flags", {12'd0, flags}, 16'b1000);

    run_instr("not_r0", mk(4'b1111, 3'd0, 3'd0, 3'd0), 1'b0, 8'h00, 5'd0);
    chk_reg("not_r0_val", 3'd0, 8'h00);
    chk("not_r0_flags", {12'd0, flags}, 16'b1010);

    run_instr("illegal", mk(4'b1010, 3'd6, 3'd2, 3'd3), 1'b1, 8'h0F, 5'd0);
    chk_reg("illegal_r6", 3'd6, 8'h78);
    chk("illegal_flags", {12'd0, flags}, 16'b1010);

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    instr       = mk(4'b0010, 3'd7, 3'd2, 3'd3);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst         = 1'b1;
    chk("rstexec_ready", {15'd0, instr_ready}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstexec_done1", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("rstexec_done2", {15'd0, done}, 16'd0);
    chk("rstexec_ready2", {15'd0, instr_ready}, 16'd1);
    chk("rstexec_flags", {12'd0, flags}, 16'd0);
    chk_reg("rstexec_r7", 3'd7, 8'h00);
    $display("txn rst_in_exec instr=%04h aborted", instr);

    // Reset during WB suppresses done
    instr       = mk(4'b1111, 3'd1, 3'd0, 3'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwb_done", {15'd0, done}, 16'd0);
    chk("rstwb_illegal", {15'd0, illegal}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwb_ready", {15'd0, instr_ready}, 16'd1);
    chk_reg("rstwb_r1", 3'd1, 8'h00);
    chk("rstwb_flags", {12'd0, flags}, 16'd0);
    $display("txn rst_in_wb instr=%04h aborted", instr);

    // Back-to-back: valid held high, second instruction waits for IDLE
    @(negedge clk);
    instr       = mk(4'b1111, 3'd1, 3'd0, 3'd0);
    instr_valid = 1'b1;
    chk("b2b_ready0", {15'd0, instr_ready}, 16'd1);
    @(negedge clk);
    instr = mk(4'b0000, 3'd2, 3'd1, 3'd1);
    chk("b2b_ready_exec", {15'd0, instr_ready}, 16'd0);
    @(negedge clk);
    chk("b2b_ready_wb", {15'd0, instr_ready}, 16'd0);
    chk("b2b_done1", {15'd0, done}, 16'd1);
    @(negedge clk);
    chk("b2b_ready_idle", {15'd0, instr_ready}, 16'd1);
    chk("b2b_done_idle", {15'd0, done}, 16'd0);
    chk_reg("b2b_r2_pre", 3'd2, 8'h00);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b_ready_exec2", {15'd0, instr_ready}, 16'd0);
    chk("b2b_ina2", {8'h00, alu_ina}, 16'h00FF);
    @(negedge clk);
    chk("b2b_done2", {15'd0, done}, 16'd1);
    @(negedge clk);
    chk_reg("b2b_r1", 3'd1, 8'hFF);
    chk_reg("b2b_r2", 3'd2, 8'hFF);
    chk("b2b_flags", {12'd0, flags}, 16'b0010);
    $display("txn back_to_back second instr=%04h done", instr);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Single-issue execute/writeback stage that sits directly upstream of the 8-bit ALU and consumes its result.
- Accepts 16-bit register-format instructions over a valid/ready handshake and reads operands from an internal 8x8-bit register file.
- Drives the ALU operand, opcode and shift-amount inputs, then captures the ALU result and flags.
- Writes the result back to the register file and holds a persistent flag register (C, V, N, Z) for later branch logic.

Parameters:
NREGS, 8, number of general registers (register-address width fixed at 3 bits; r0 reads as zero)
FLAG_CV_ADDSUB_ONLY, 1, when 1, the C/V flags update only on ADD/SUB and hold on all other ops

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction word present on instr
instr_ready  output  1  stage can accept an instruction (high only in IDLE)
instr  input  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [4:0] shamt for shift/rotate ops
alu_ina  output  8  operand A to ALU (value of rs1)
alu_inb  output  8  operand B to ALU (value of rs2)
alu_op  output  4  ALU operation code
alu_shamt  output  5  shift/rotate amount
alu_out  input  8  ALU result
alu_cr  input  1  ALU carry
alu_ov  input  1  ALU overflow
alu_ng  input  1  ALU negative
alu_zr  input  1  ALU zero
done  output  1  one-cycle pulse in the WB cycle
illegal  output  1  one-cycle pulse in the WB cycle when the opcode is unsupported
flags  output  4  {C,V,N,Z}, registered
dbg_addr  input  3  debug read address
dbg_data  output  8  combinational read of the register file (r0 reads 0)

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values:
  - State returns to IDLE.
  - All registers are cleared to 0 and flags are 0000.
  - done = 0 and illegal = 0.
  - alu_ina, alu_inb, alu_op and alu_shamt are 0; alu_op = 0000 is the AND code.
- Legal opcodes: ADD 0010, SUB 0110, AND 0000, OR 0001, NOT 1111, SLT 0111, LS 0011, URS 0101, SRS 0100, RRO 1000, LRO 1001. All other codes are illegal.
- State machine IDLE -> EXEC -> WB -> IDLE:
  - IDLE: instr_ready = 1. On instr_valid && instr_ready, latch instr, read rs1 and rs2 into operand registers, and go to EXEC.
  - EXEC: alu_* outputs are driven from the operand registers. This is a one-cycle settle for the combinational ALU. instr_ready = 0.
  - WB: sample alu_out and the flags. If the opcode is legal and rd != 0, write rd. Update flags and pulse done. If the opcode is illegal, pulse done and illegal with no register or flag change. Return to IDLE.
- Latency and throughput:
  - Accept in cycle N, WB in cycle N+2, next accept in N+3.
  - Throughput is one instruction per 3 cycles.
- Operand source: operands are read at accept time. Because the stage is single-issue, a previous write has always completed before the next read.
- Flag rules:
  - N and Z update on every legal op.
  - C and V update on ADD and SUB only (when FLAG_CV_ADDSUB_ONLY = 1) and otherwise hold their previous values.
- alu_shamt = instr[4:0] for LS, URS, SRS, RRO and LRO, and 0 otherwise. alu_inb is still driven with rs2 for these ops, and the ALU ignores it.
- r0:
  - Reads return 0 on both the operand read and the dbg_data path.
  - Writes to r0 are dropped, but the flags still update.
- instr_valid outside IDLE is ignored, and the instruction is not consumed.
- Reset mid-operation: rst in EXEC or WB aborts the instruction. There is no writeback, no done pulse and no flag change; state goes to IDLE next cycle.
- alu_op, alu_ina and alu_inb hold their last values in IDLE; no glitch requirement.

Test Plan:
- Reset, then ADD r1=r0+r0 -> done at accept+2; r1=0x00, flags Z=1, C=0, V=0.
- Preload r2=0x7F and r3=0x01 (via ADD from known values), then ADD r4=r2+r3 -> r4=0x80, flags N=1, V=1, C=0, Z=0.
- SUB r5=r3-r3 with r3=0x01 -> r5=0x00, Z=1, C=1; a following AND updates only N and Z, and C stays 1.
- LS r6=r2<<3 with r2=0x0F and instr[4:0]=3 -> alu_shamt=3, r6=0x78.
- Opcode 1010 -> illegal and done pulse in the same cycle; register file and flags unchanged; instr_ready returns the next cycle.
- Assert rst in the EXEC cycle of ADD r7 -> no write to r7 (dbg_data=0), no done pulse, state IDLE with instr_ready=1 after reset deasserts. Back-to-back valid with ready low -> the second instruction is accepted only in the cycle after WB.
